// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - four-digit multiplexed 7-segment driver for a 4-bit down-counter value
// Optional feature: define LEADING_ZERO_BLANK_EN to blank the tens digit for values below 10.

module seg7_scan_driver #(
    parameter int DWELL_CYC = 25000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic [3:0] Q,
    input  logic       load,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int            PW      = $clog2(DWELL_CYC);
    localparam logic [PW-1:0] P_LAST  = PW'(DWELL_CYC - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYC);
    localparam logic [6:0]    SEG_OFF = 7'b1111111;
    localparam logic [6:0]    SEG_U   = 7'b1000001;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    logic [3:0]    held_q, held_d;
    logic          wrap_q, wrap_d;
    logic [4:0]    frame_q, frame_d;
    logic [PW-1:0] p_q, p_d;
    logic [1:0]    d_q, d_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic       p_wrap;
    logic       ge_ten;
    logic [3:0] frame_val;
    logic [3:0] units;
    logic [6:0] tens_glyph;

    always_comb begin
        held_d = held_q;
        wrap_d = wrap_q;
        if (load) begin
            held_d = Q;
            wrap_d = (held_q == 4'd0) && (Q == 4'd15);
        end

        p_wrap = (p_q == P_LAST);
        p_d    = p_wrap ? '0 : p_q + 1'b1;
        d_d    = p_wrap ? d_q + 2'd1 : d_q;

        // Snapshot taken with post-load values so a load on the wrap edge is shown immediately.
        frame_d = (p_d == '0) ? {wrap_d, held_d} : frame_q;
    end

    // Outputs are computed from next-state p/d/frame so the registered outputs line up with p_q/d_q.
    always_comb begin
        frame_val = frame_d[3:0];
        ge_ten    = (frame_val >= 4'd10);
        units     = ge_ten ? frame_val - 4'd10 : frame_val;
`ifdef LEADING_ZERO_BLANK_EN
        tens_glyph = ge_ten ? hex_glyph(4'd1) : SEG_OFF;
`else
        tens_glyph = ge_ten ? hex_glyph(4'd1) : hex_glyph(4'd0);
`endif

        an_d  = 4'b1111;
        seg_d = SEG_OFF;
        if (p_d >= P_BLANK) begin
            an_d = ~(4'b0001 << d_d);
            case (d_d)
                2'd0:    seg_d = hex_glyph(units);
                2'd1:    seg_d = tens_glyph;
                2'd2:    seg_d = hex_glyph(frame_val);
                default: seg_d = frame_d[4] ? SEG_U : SEG_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            held_q  <= 4'd0;
            wrap_q  <= 1'b0;
            frame_q <= 5'd0;
            p_q     <= '0;
            d_q     <= 2'd0;
            an_q    <= 4'b1111;
            seg_q   <= SEG_OFF;
        end else begin
            held_q  <= held_d;
            wrap_q  <= wrap_d;
            frame_q <= frame_d;
            p_q     <= p_d;
            d_q     <= d_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver (DWELL_CYC=8, BLANK_CYC=2)

module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       Reset_n;
    logic [3:0] Q;
    logic       load;
    logic [3:0] an;
    logic [6:0] seg;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [6:0] glyph [16];

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DWELL_CYC(8),
        .BLANK_CYC(2)
    ) dut (
        .clk    (clk),
        .Reset_n(Reset_n),
        .Q      (Q),
        .load   (load),
        .an     (an),
        .seg    (seg)
    );

    task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (cyc %0d): got an=%b seg=%b, expected an=%b seg=%b",
                     tag, cyc, got[10:7], got[6:0], exp[10:7], exp[6:0]);
        end
    endtask

    // cyc counts edges since the last reset edge, so p = cyc%8 and d = (cyc/8)%4.
    task automatic step();
        logic rst_edge;
        rst_edge = !Reset_n;
        @(posedge clk);
        #1;
        if (rst_edge) cyc = 0;
        else          cyc++;
    endtask

    task automatic do_load(input logic [3:0] q);
        Q    = q;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic to_boundary();
        while (cyc % 32 != 0) step();
    endtask

    function automatic logic [10:0] expect_out(input int c, input int v, input logic w);
        int         p;
        int         d;
        logic [3:0] a;
        logic [6:0] s;
        p = c % 8;
        d = (c / 8) % 4;
        if (p < 2) return {4'b1111, 7'b1111111};
        a = ~(4'b0001 << d);
        case (d)
            0:       s = glyph[v % 10];
`ifdef LEADING_ZERO_BLANK_EN
            1:       s = (v >= 10) ? glyph[1] : 7'b1111111;
`else
            1:       s = (v >= 10) ? glyph[1] : glyph[0];
`endif
            2:       s = glyph[v];
            default: s = w ? 7'b1000001 : 7'b1111111;
        endcase
        return {a, s};
    endfunction

    task automatic scan_check(input string tag, input int v, input logic w);
        for (int i = 0; i < 32; i++) begin
            check(tag, {an, seg}, expect_out(cyc, v, w));
            step();
        end
    endtask

    initial begin
        glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
        glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010; glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
        glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
        glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;

        Reset_n = 1'b0;
        load    = 1'b0;
        Q       = 4'd0;

        repeat (5) begin
            step();
            check("reset", {an, seg}, {4'b1111, 7'b1111111});
        end
        Reset_n = 1'b1;
        check("rel_p0", {an, seg}, {4'b1111, 7'b1111111});
        step();
        check("rel_p1", {an, seg}, {4'b1111, 7'b1111111});
        step();
        check("rel_p2", {an, seg}, {4'b1110, 7'b1000000});

        do_load(4'd13);
        to_boundary();
        check("scan13_d0", {4'b1110, 7'b0110000}, expect_out(2, 13, 1'b0));
        scan_check("scan13", 13, 1'b0);

        do_load(4'd0);
        do_load(4'd15);
        to_boundary();
        scan_check("wrap15", 15, 1'b1);

        do_load(4'd14);
        to_boundary();
        scan_check("clr14", 14, 1'b0);

        do_load(4'd3);
        to_boundary();
        repeat (4) begin
            check("mid_pre", {an, seg}, expect_out(cyc, 3, 1'b0));
            step();
        end
        check("mid_p4", {an, seg}, {4'b1110, 7'b0110000});
        do_load(4'd7);
        check("mid_p5", {an, seg}, {4'b1110, 7'b0110000});
        while (cyc % 32 < 16) begin
            check("mid_post", {an, seg}, expect_out(cyc, (cyc % 32 < 8) ? 3 : 7, 1'b0));
            step();
        end

        do_load(4'd5);
        to_boundary();
        repeat (10) step();
`ifdef LEADING_ZERO_BLANK_EN
        check("val5_d1", {an, seg}, {4'b1101, 7'b1111111});
`else
        check("val5_d1", {an, seg}, {4'b1101, 7'b1000000});
`endif
        to_boundary();
        scan_check("val5", 5, 1'b0);

        while (cyc % 32 != 21) step();
        Reset_n = 1'b0;
        load    = 1'b1;
        Q       = 4'd9;
        step();
        check("midrst", {an, seg}, {4'b1111, 7'b1111111});
        Reset_n = 1'b1;
        load    = 1'b0;
        scan_check("after_rst", 0, 1'b0);

        do_load(4'd15);
        to_boundary();
        scan_check("rst_wrap", 15, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter: DWELL_CYC, default 25000, clk cycles each digit is selected (phase counter period), legal range 4..65535.
REQ-002 Parameter: BLANK_CYC, default 16, leading cycles of each dwell with all anodes off (anti-ghosting); SHALL be < DWELL_CYC.
REQ-003 Port: clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port: Reset_n  input  1  synchronous, active-low reset.
REQ-005 Port: Q  input  4  down-counter value to display.
REQ-006 Port: load  input  1  when high at a rising edge, Q is captured.
REQ-007 Port: an  output  4  digit anodes, active-low, an[0] = rightmost.
REQ-008 Port: seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-009 Capture: on an edge with load=1, held <= Q; load=0 leaves held unchanged.
REQ-010 Wrap flag: on a load with held==0 and Q==15, wrap <= 1; on any other load, wrap <= 0.
REQ-011 Phase counter p counts 0..DWELL_CYC-1, then wraps to 0; digit index d advances 0->1->2->3->0 on the same edge as p wraps to 0.
REQ-012 Snapshot: on the edge where p becomes 0, frame register <= {wrap, held} (using post-load values if load is high on that edge); glyphs use only the frame register, so they stay constant within a dwell.
REQ-013 Outputs registered; in the cycle where p and d hold given values, an and seg reflect those values.
REQ-014 Blanking: while p < BLANK_CYC, an = 4'b1111; otherwise an = ~(4'b0001 << d).
REQ-015 Digit 0: decimal units of frame value (0..9).
REQ-016 Digit 1: decimal tens of frame value (0 or 1).
REQ-017 Digit 2: hex glyph of frame value (0-9, A, b, C, d, E, F).
REQ-018 Digit 3: 'U' (7'b1000001) if frame wrap=1, else blank (7'b1111111).
REQ-019 Glyph table (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-020 While an = 4'b1111, seg SHALL equal 7'b1111111.
REQ-021 Load on every edge is legal; only the value present at snapshot is displayed.

Reset
REQ-022 Reset_n=0 at an edge: held=0, wrap=0, frame=0, p=0, d=0, an=4'b1111, seg=7'b1111111; load is ignored on that edge.
REQ-023 Reset has priority over load and counter advance; a reset mid-dwell restarts at p=0, d=0 on the next edge with Reset_n=1.
REQ-024 First cycle after release: p=0, d=0, so an stays 4'b1111 for BLANK_CYC cycles.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN: when defined, digit 1 shows blank (7'b1111111) when frame value < 10.
REQ-026 When LEADING_ZERO_BLANK_EN is undefined, digit 1 shows '0' (7'b1000000) for values < 10; all other behaviour is identical.

Verification (bench params DWELL_CYC=8, BLANK_CYC=2)
REQ-027 Reset: hold Reset_n=0 for 5 cycles, then release -> an=1111 and seg=1111111 during reset and for 2 cycles after; an=1110 from p=2, with seg=1000000 (digit 0, value 0).
REQ-028 Scan order: load Q=13, then run 32 cycles -> each 8-cycle dwell shows 2 blank cycles and 6 active cycles; an sequence 1110/1101/1011/0111 with seg 0110000 ('3'), 1111001 ('1'), 0100001 ('d'), 1111111.
REQ-029 Wrap: load Q=0, then load Q=15 -> after the next snapshot, digit 3 shows 1000001 and digit 2 shows 0001110; a later load of Q=14 clears 'U' from the next dwell.
REQ-030 Mid-dwell load: load Q=7 at p=4 during digit 0 with frame value 3 -> digit 0 keeps 0110000 until the dwell ends; the next dwell (digit 1) uses value 7.
REQ-031 Macro: value 5 with LEADING_ZERO_BLANK_EN defined -> digit 1 seg=1111111; with it undefined -> digit 1 seg=1000000.
REQ-032 Reset mid-scan: assert Reset_n=0 during digit 2 at p=5 for 1 cycle -> the next cycle shows an=1111, and scanning restarts at digit 0 with held=0 and wrap=0.
